// File: rtl/mac_host.sv
// Host-side initiator for the bit-serial MAC: takes parallel A/B/C, drives one
// serial START/READY/END transaction, and returns the deserialised A*B+C with an error flag.
module mac_host #(
    parameter int A_W = 4,
    parameter int C_W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [A_W-1:0] A_IN,
    input  logic [A_W-1:0] B_IN,
    input  logic [C_W-1:0] C_IN,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [C_W:0]   RESULT,
    output logic           ERR,
    output logic           MAC_START,
    input  logic           MAC_READY,
    output logic           MAC_A,
    output logic           MAC_B,
    output logic           MAC_C,
    input  logic           MAC_O,
    input  logic           MAC_O_VALID,
    input  logic           MAC_END
);

    localparam int K_W = $clog2(C_W + 3);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [K_W-1:0] K_LAST = K_W'(C_W + 1);
    localparam logic [K_W-1:0] K_A    = K_W'(A_W);
    localparam logic [K_W-1:0] K_C    = K_W'(C_W);

    logic [1:0]     state_r;
    logic [K_W-1:0] k_r;
    logic [K_W-1:0] nbits_r;
    logic [K_W-1:0] nbits_nx_s;
    logic [A_W-1:0] a_sh_r;
    logic [A_W-1:0] b_sh_r;
    logic [C_W-1:0] c_sh_r;
    logic [C_W:0]   res_r;
    logic [C_W:0]   res_nx_s;
    logic           err_r;
    logic           end_early_r;

    // Result capture: shift serial O in from the top so the first bit lands at the LSB.
    always_comb begin
        res_nx_s   = res_r;
        nbits_nx_s = nbits_r;
        if ((state_r == RUN) && MAC_O_VALID) begin
            res_nx_s   = {MAC_O, res_r[C_W:1]};
            nbits_nx_s = nbits_r + K_W'(1);
        end else begin
            res_nx_s   = res_r;
            nbits_nx_s = nbits_r;
        end
    end

    // Transaction sequencer and operand/result shift registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            k_r         <= '0;
            nbits_r     <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            c_sh_r      <= '0;
            res_r       <= '0;
            err_r       <= 1'b0;
            end_early_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (IN_VALID) begin
                        a_sh_r      <= A_IN;
                        b_sh_r      <= B_IN;
                        c_sh_r      <= C_IN;
                        res_r       <= '0;
                        nbits_r     <= '0;
                        err_r       <= 1'b0;
                        end_early_r <= 1'b0;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (MAC_READY) begin
                        k_r     <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_sh_r  <= {1'b0, a_sh_r[A_W-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[A_W-1:1]};
                    c_sh_r  <= {1'b0, c_sh_r[C_W-1:1]};
                    res_r   <= res_nx_s;
                    nbits_r <= nbits_nx_s;
                    if (k_r == K_LAST) begin
                        err_r   <= !MAC_END || (nbits_nx_s != K_LAST) || end_early_r;
                        state_r <= DONE;
                    end else begin
                        k_r <= k_r + K_W'(1);
                        if (MAC_END) begin
                            end_early_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Every output is a decode of flops only; nothing from the MAC side passes through.
    assign IN_READY  = (state_r == IDLE);
    assign OUT_VALID = (state_r == DONE);
    assign RESULT    = res_r;
    assign ERR       = err_r;
    assign MAC_START = (state_r == RUN) && (k_r == '0);
    assign MAC_A     = ((state_r == RUN) && (k_r < K_A)) ? a_sh_r[0] : 1'b0;
    assign MAC_B     = ((state_r == RUN) && (k_r < K_A)) ? b_sh_r[0] : 1'b0;
    assign MAC_C     = ((state_r == RUN) && (k_r < K_C)) ? c_sh_r[0] : 1'b0;

endmodule
